// File: rtl/intel_vvp_reset_sequencer.sv
// -----------------------------------------------------------------------------
// intel_vvp_reset_sequencer
//
// Holds a bank of downstream reset domains asserted until the PLL has been
// locked for a stable period and a minimum hold time has elapsed, then
// releases the domains one at a time in index order with a fixed gap between
// releases. Loss of lock or a software reset request re-asserts every output
// and restarts the sequence. The software request is acknowledged with a
// four-phase req/ack handshake once the full hold time has been served.
//
// Ports:
//   clk         sole clock
//   rst_n       asynchronous active-low reset
//   pll_locked  PLL lock indication, asynchronous to clk
//   sw_rst_req  software reset request (level, synchronous to clk)
//   sw_rst_ack  software reset acknowledge
//   rst_out     active-high resets, bit 0 released first
//   rst_done    high once every output has been released
//   seq_state   debug: 0=ASSERT, 1=RELEASE, 2=DONE
// -----------------------------------------------------------------------------
module intel_vvp_reset_sequencer #(
    parameter int NUM_OUTPUTS = 4,
    parameter int HOLD_CYCLES = 256,
    parameter int LOCK_STABLE = 64,
    parameter int STAGE_GAP   = 16,
    parameter int SYNC_LEN    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   sw_rst_req,
    output logic                   sw_rst_ack,
    output logic [NUM_OUTPUTS-1:0] rst_out,
    output logic                   rst_done,
    output logic [1:0]             seq_state
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int LOCK_W = $clog2(LOCK_STABLE) + 1;
    localparam int GAP_W  = $clog2(STAGE_GAP - 1) + 1;
    localparam int IDX_W  = $clog2(NUM_OUTPUTS - 1) + 1;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_STABLE);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_OUTPUTS - 1);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [SYNC_LEN-1:0]    sync_r;
    logic [1:0]             state_r,     state_nxt_s;
    logic [HOLD_W-1:0]      hold_cnt_r,  hold_cnt_nxt_s;
    logic [LOCK_W-1:0]      lock_cnt_r,  lock_cnt_nxt_s;
    logic [GAP_W-1:0]       gap_cnt_r,   gap_cnt_nxt_s;
    logic [IDX_W-1:0]       stage_idx_r, stage_idx_nxt_s;
    logic [NUM_OUTPUTS-1:0] rst_out_r,   rst_out_nxt_s;
    logic                   rst_done_r,  rst_done_nxt_s;
    logic                   ack_r,       ack_nxt_s;

    logic lock_sync_s;
    logic hold_done_s;
    logic lock_done_s;
    logic abort_s;

    assign lock_sync_s = sync_r[SYNC_LEN-1];
    assign hold_done_s = (hold_cnt_r == HOLD_MAX);
    assign lock_done_s = (lock_cnt_r == LOCK_MAX);
    // Only a running or finished sequence can be aborted; ASSERT already holds.
    assign abort_s     = (state_r != ST_ASSERT) && (!lock_sync_s || sw_rst_req);

    // Synchronise the asynchronous PLL lock into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_LEN-2:0], pll_locked};
        end
    end

    // Software acknowledge: rises once the full hold has been served while the
    // request is up, stays up with the request, drops the edge after it falls.
    always_comb begin
        ack_nxt_s = sw_rst_req && (ack_r || ((state_r == ST_ASSERT) && hold_done_s));
    end

    // Sequencer next-state, counters and output images.
    always_comb begin
        state_nxt_s     = state_r;
        hold_cnt_nxt_s  = hold_cnt_r;
        lock_cnt_nxt_s  = lock_cnt_r;
        gap_cnt_nxt_s   = gap_cnt_r;
        stage_idx_nxt_s = stage_idx_r;
        rst_out_nxt_s   = rst_out_r;
        rst_done_nxt_s  = rst_done_r;

        if (abort_s) begin
            // Abort wins over any release scheduled for the same edge.
            state_nxt_s     = ST_ASSERT;
            hold_cnt_nxt_s  = '0;
            lock_cnt_nxt_s  = '0;
            gap_cnt_nxt_s   = '0;
            stage_idx_nxt_s = '0;
            rst_out_nxt_s   = '1;
            rst_done_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_ASSERT: begin
                    rst_out_nxt_s  = '1;
                    rst_done_nxt_s = 1'b0;
                    hold_cnt_nxt_s = hold_done_s ? hold_cnt_r : hold_cnt_r + HOLD_W'(1);
                    if (!lock_sync_s) begin
                        lock_cnt_nxt_s = '0;
                    end else if (!lock_done_s) begin
                        lock_cnt_nxt_s = lock_cnt_r + LOCK_W'(1);
                    end else begin
                        lock_cnt_nxt_s = lock_cnt_r;
                    end
                    // Leaving also waits for ack to drop so the software
                    // handshake completes all four phases before release.
                    if (hold_done_s && lock_done_s && !sw_rst_req && !ack_r) begin
                        rst_out_nxt_s[0] = 1'b0;
                        gap_cnt_nxt_s    = '0;
                        if (NUM_OUTPUTS == 1) begin
                            state_nxt_s     = ST_DONE;
                            rst_done_nxt_s  = 1'b1;
                            stage_idx_nxt_s = '0;
                        end else begin
                            state_nxt_s     = ST_RELEASE;
                            rst_done_nxt_s  = 1'b0;
                            stage_idx_nxt_s = IDX_W'(1);
                        end
                    end else begin
                        state_nxt_s = ST_ASSERT;
                    end
                end
                ST_RELEASE: begin
                    if (gap_cnt_r == GAP_MAX) begin
                        for (int i = 0; i < NUM_OUTPUTS; i++) begin
                            rst_out_nxt_s[i] = (IDX_W'(i) == stage_idx_r) ? 1'b0 : rst_out_r[i];
                        end
                        gap_cnt_nxt_s = '0;
                        if (stage_idx_r == IDX_LAST) begin
                            state_nxt_s    = ST_DONE;
                            rst_done_nxt_s = 1'b1;
                        end else begin
                            stage_idx_nxt_s = stage_idx_r + IDX_W'(1);
                        end
                    end else begin
                        gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    // Unreachable encoding: fall back to the safe state.
                    state_nxt_s    = ST_ASSERT;
                    hold_cnt_nxt_s = '0;
                    lock_cnt_nxt_s = '0;
                    rst_out_nxt_s  = '1;
                    rst_done_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_ASSERT;
            hold_cnt_r  <= '0;
            lock_cnt_r  <= '0;
            gap_cnt_r   <= '0;
            stage_idx_r <= '0;
            rst_out_r   <= '1;
            rst_done_r  <= 1'b0;
            ack_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            lock_cnt_r  <= lock_cnt_nxt_s;
            gap_cnt_r   <= gap_cnt_nxt_s;
            stage_idx_r <= stage_idx_nxt_s;
            rst_out_r   <= rst_out_nxt_s;
            rst_done_r  <= rst_done_nxt_s;
            ack_r       <= ack_nxt_s;
        end
    end

    assign sw_rst_ack = ack_r;
    assign rst_out    = rst_out_r;
    assign rst_done   = rst_done_r;
    assign seq_state  = state_r;

endmodule

// File: tb/tb_intel_vvp_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_intel_vvp_reset_sequencer
//
// Directed table of timed expectations (power-up, late lock, lock glitches,
// software handshake, abort colliding with a release) plus an asynchronous
// reset sequence, followed by randomized lock/request/reset stimulus checked
// cycle by cycle against a timeline model of the sequencer.
// -----------------------------------------------------------------------------
module tb_intel_vvp_reset_sequencer;

    localparam int P_N    = 3;
    localparam int P_HOLD = 8;
    localparam int P_LOCK = 4;
    localparam int P_GAP  = 4;
    localparam int P_SYNC = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           pll_locked;
    logic           sw_rst_req;
    logic           sw_rst_ack;
    logic [P_N-1:0] rst_out;
    logic           rst_done;
    logic [1:0]     seq_state;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    intel_vvp_reset_sequencer #(
        .NUM_OUTPUTS(P_N),
        .HOLD_CYCLES(P_HOLD),
        .LOCK_STABLE(P_LOCK),
        .STAGE_GAP  (P_GAP),
        .SYNC_LEN   (P_SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .sw_rst_req(sw_rst_req),
        .sw_rst_ack(sw_rst_ack),
        .rst_out   (rst_out),
        .rst_done  (rst_done),
        .seq_state (seq_state)
    );

    always #5 clk = ~clk;

    // ---------------- comparison -------------------------------------------
    // Packed expectation: {rst_out[2:0], rst_done, sw_rst_ack, seq_state[1:0]}
    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {rst_out, rst_done, sw_rst_ack, seq_state};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d: got rst_out=%b done=%b ack=%b state=%0d, expected rst_out=%b done=%b ack=%b state=%0d",
                     name, edge_n, got[6:4], got[3], got[2], got[1:0],
                     exp[6:4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        string      name;
        bit         restart;  // pulse rst_n and check reset values, edge count -> 0
        int         at_edge;  // edge after rst_n release at which to sample
        logic [6:0] exp;
        bit         pll_nxt;  // levels driven after this sample (or during reset)
        bit         req_nxt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input bit restart, input int at_edge,
                                input logic [2:0] r, input bit d, input bit a,
                                input logic [1:0] st, input bit pll, input bit req);
        vec_t v;
        v.name    = name;
        v.restart = restart;
        v.at_edge = at_edge;
        v.exp     = {r, d, a, st};
        v.pll_nxt = pll;
        v.req_nxt = req;
        return v;
    endfunction

    // ---------------- timeline reference model -----------------------------
    // The sequencer is viewed as: an ASSERT phase with an age and a run length
    // of stable lock, then a release phase where the number of released
    // outputs is simply 1 + elapsed/STAGE_GAP, capped at NUM_OUTPUTS.
    bit m_in_assert;
    int m_age;
    int m_lrun;
    int m_elapsed;
    bit m_ack;
    bit m_q[$];

    task automatic model_reset();
        m_in_assert = 1'b1;
        m_age       = 0;
        m_lrun      = 0;
        m_elapsed   = 0;
        m_ack       = 1'b0;
        m_q.delete();
        for (int i = 0; i < P_SYNC; i++) m_q.push_back(1'b0);
    endtask

    task automatic model_step(input bit pll, input bit req);
        bit ls;
        bit nack;
        ls   = m_q[0];
        nack = req && (m_ack || (m_in_assert && m_age >= P_HOLD));
        if (m_in_assert) begin
            if (m_age >= P_HOLD && m_lrun >= P_LOCK && !req && !m_ack) begin
                m_in_assert = 1'b0;
                m_elapsed   = 0;
            end else begin
                m_age  = m_age + 1;
                m_lrun = ls ? m_lrun + 1 : 0;
            end
        end else if (!ls || req) begin
            m_in_assert = 1'b1;
            m_age       = 0;
            m_lrun      = 0;
        end else begin
            m_elapsed = m_elapsed + 1;
        end
        m_ack = nack;
        void'(m_q.pop_front());
        m_q.push_back(pll);
    endtask

    function automatic logic [6:0] model_out();
        int         rel;
        logic [2:0] r;
        bit         d;
        logic [1:0] st;
        rel = m_in_assert ? 0 : 1 + m_elapsed / P_GAP;
        if (rel > P_N) rel = P_N;
        for (int i = 0; i < P_N; i++) r[i] = (i < rel) ? 1'b0 : 1'b1;
        d  = (rel == P_N);
        st = m_in_assert ? 2'd0 : (d ? 2'd2 : 2'd1);
        return {r, d, m_ack, st};
    endfunction

    // ---------------- stimulus ---------------------------------------------
    initial begin
        int pll_low_left;
        int req_left;
        vec_t v;

        rst_n      = 1'b0;
        pll_locked = 1'b1;
        sw_rst_req = 1'b0;

        // Reset state, then async reset in the middle of RELEASE.
        @(posedge clk); #1;
        check("reset_state", {3'b111, 1'b0, 1'b0, 2'd0});
        @(posedge clk); #1;
        rst_n  = 1'b1;
        edge_n = 0;
        while (edge_n < 14) begin @(posedge clk); edge_n++; end
        #1;
        check("pre_async_release", {3'b100, 1'b0, 1'b0, 2'd1});
        #2 rst_n = 1'b0;
        #1 check("async_mid_sequence", {3'b111, 1'b0, 1'b0, 2'd0});

        // Power-up after the async reset, then software reset from DONE.
        vecs.push_back(mk("pwr_reset",    1,  0, 3'b111, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk("pwr_e8",       0,  8, 3'b111, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk("pwr_e9",       0,  9, 3'b110, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk("pwr_e12",      0, 12, 3'b110, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk("pwr_e13",      0, 13, 3'b100, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk("pwr_e16",      0, 16, 3'b100, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk("pwr_e17",      0, 17, 3'b000, 1, 0, 2'd2, 1, 0));
        vecs.push_back(mk("sw_done",      0, 20, 3'b000, 1, 0, 2'd2, 1, 1));
        vecs.push_back(mk("sw_abort",     0, 21, 3'b111, 0, 0, 2'd0, 1, 1));
        vecs.push_back(mk("sw_no_ack",    0, 29, 3'b111, 0, 0, 2'd0, 1, 1));
        vecs.push_back(mk("sw_ack_rise",  0, 30, 3'b111, 0, 1, 2'd0, 1, 1));
        vecs.push_back(mk("sw_ack_hold",  0, 32, 3'b111, 0, 1, 2'd0, 1, 0));
        vecs.push_back(mk("sw_ack_fall",  0, 33, 3'b111, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk("sw_release",   0, 34, 3'b110, 0, 0, 2'd1, 1, 0));
        // Late lock.
        vecs.push_back(mk("late_reset",   1,  0, 3'b111, 0, 0, 2'd0, 0, 0));
        vecs.push_back(mk("late_e20",     0, 20, 3'b111, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk("late_e26",     0, 26, 3'b111, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk("late_e27",     0, 27, 3'b110, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk("late_e31",     0, 31, 3'b100, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk("late_e34",     0, 34, 3'b100, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk("late_e35",     0, 35, 3'b000, 1, 0, 2'd2, 1, 0));
        // Lock glitch during RELEASE, then abort colliding with a release edge.
        vecs.push_back(mk("glr_reset",    1,  0, 3'b111, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk("glr_e9",       0,  9, 3'b110, 0, 0, 2'd1, 0, 0));
        vecs.push_back(mk("glr_e10",      0, 10, 3'b110, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk("glr_e11",      0, 11, 3'b110, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk("glr_abort",    0, 12, 3'b111, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk("glr_rehold",   0, 20, 3'b111, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk("glr_rerel",    0, 21, 3'b110, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk("sim_e22",      0, 22, 3'b110, 0, 0, 2'd1, 0, 0));
        vecs.push_back(mk("sim_e23",      0, 23, 3'b110, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk("sim_e24",      0, 24, 3'b110, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk("sim_abort",    0, 25, 3'b111, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk("sim_e33",      0, 33, 3'b111, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk("sim_e34",      0, 34, 3'b110, 0, 0, 2'd1, 1, 0));
        // Lock glitch during ASSERT delays release from edge 9 to edge 11.
        vecs.push_back(mk("gla_reset",    1,  0, 3'b111, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk("gla_e3",       0,  3, 3'b111, 0, 0, 2'd0, 0, 0));
        vecs.push_back(mk("gla_e4",       0,  4, 3'b111, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk("gla_e9",       0,  9, 3'b111, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk("gla_e10",      0, 10, 3'b111, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk("gla_e11",      0, 11, 3'b110, 0, 0, 2'd1, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.restart) begin
                rst_n      = 1'b0;
                pll_locked = v.pll_nxt;
                sw_rst_req = v.req_nxt;
                @(posedge clk); #1;
                check(v.name, v.exp);
                @(posedge clk); #1;
                rst_n  = 1'b1;
                edge_n = 0;
            end else begin
                while (edge_n < v.at_edge) begin @(posedge clk); edge_n++; end
                #1;
                check(v.name, v.exp);
                pll_locked = v.pll_nxt;
                sw_rst_req = v.req_nxt;
            end
        end

        // Randomized lock drops, request episodes and reset pulses.
        rst_n        = 1'b0;
        pll_locked   = 1'b1;
        sw_rst_req   = 1'b0;
        pll_low_left = 0;
        req_left     = 0;
        model_reset();
        @(posedge clk); #1;
        rst_n  = 1'b1;
        edge_n = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1 check("rand_async_reset", model_out());
                @(posedge clk); #1;
                rst_n = 1'b1;
            end else begin
                if (pll_low_left > 0) begin
                    pll_locked   = 1'b0;
                    pll_low_left = pll_low_left - 1;
                end else if ($urandom_range(0, 39) == 0) begin
                    pll_locked   = 1'b0;
                    pll_low_left = int'($urandom_range(0, 2));
                end else begin
                    pll_locked = 1'b1;
                end
                if (req_left > 0) begin
                    sw_rst_req = 1'b1;
                    req_left   = req_left - 1;
                end else if ($urandom_range(0, 99) == 0) begin
                    sw_rst_req = 1'b1;
                    req_left   = int'($urandom_range(0, 29));
                end else begin
                    sw_rst_req = 1'b0;
                end
                model_step(pll_locked, sw_rst_req);
                @(posedge clk);
                edge_n++;
                #1;
                check("rand_cycle", model_out());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
